uart_tx: RTL

UART serial transmitter, the transmit-side companion of the UART RX path. It accepts a parallel byte with a valid/busy handshake and serialises one frame on `tx_out`: start bit, 8 data bits LSB first, optional parity bit, and one stop bit. Bit timing uses the same `prescale` clocks-per-bit convention as the receiver, so both ends share one configuration register.

---
 rtl/uart_tx.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx : UART serial transmitter.
//
// Serialises one byte per request as: start bit (0), 8 data bits LSB first,
// optional parity bit, one stop bit (1). A bit lasts `prescale` clocks, with
// prescale = 0 meaning 64 clocks, because the 6-bit edge counter wraps.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : PARITY state present; PAR_EN / PAR_TYP honoured.
//   undefined : no parity logic; PAR_EN / PAR_TYP are ignored and every
//               frame is 10 bits long.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   data_in     in   byte to transmit (captured on acceptance)
//   data_valid  in   transmit request, accepted when busy = 0
//   PAR_EN      in   parity enable (captured on acceptance)
//   PAR_TYP     in   parity type, 0 = even, 1 = odd (captured on acceptance)
//   prescale    in   clocks per bit, 0 -> 64 (captured on acceptance)
//   tx_out      out  serial line, registered, idles high
//   busy        out  frame in progress, registered
//   tx_done     out  one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            prescale,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t                  state_reg, state_next;
  logic [5:0]              edge_cnt_reg, edge_cnt_next;
  logic [2:0]              bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic [5:0]              prescale_reg, prescale_next;
  logic                    tx_out_reg, tx_out_next;
  logic                    busy_reg, busy_next;
  logic                    tx_done_reg, tx_done_next;

  // Last clock of the current bit: the incremented edge count hits the
  // captured prescale. With prescale = 0 this happens when 63 wraps to 0.
  logic [5:0]              edge_inc;
  logic                    bit_end;

  assign edge_inc = edge_cnt_reg + 6'd1;
  assign bit_end  = (edge_inc == prescale_reg);

`ifdef UART_TX_PARITY_EN
  logic par_en_reg, par_en_next;
  logic par_typ_reg, par_typ_next;
  logic parity_bit;

  // XOR of the data bits gives even parity; PAR_TYP = 1 flips it to odd.
  assign parity_bit = (^data_reg) ^ par_typ_reg;
`else
  // Parity inputs are part of the port list in every build but have no
  // function without the parity feature.
  logic unused_par_inputs;
  assign unused_par_inputs = PAR_EN ^ PAR_TYP;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      prescale_reg <= '0;
      tx_out_reg   <= 1'b1;
      busy_reg     <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      edge_cnt_reg <= edge_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_reg     <= data_next;
      prescale_reg <= prescale_next;
      tx_out_reg   <= tx_out_next;
      busy_reg     <= busy_next;
      tx_done_reg  <= tx_done_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
    end else begin
      par_en_reg  <= par_en_next;
      par_typ_reg <= par_typ_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    edge_cnt_next = edge_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_next     = data_reg;
    prescale_next = prescale_reg;
    tx_done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_next   = par_en_reg;
    par_typ_next  = par_typ_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (data_valid) begin
          data_next     = data_in;
          prescale_next = prescale;
`ifdef UART_TX_PARITY_EN
          par_en_next   = PAR_EN;
          par_typ_next  = PAR_TYP;
`endif
          edge_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          edge_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = S_DATA;
        end else begin
          edge_cnt_next = edge_inc;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          edge_cnt_next = '0;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = par_en_reg ? S_PARITY : S_STOP;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          edge_cnt_next = edge_inc;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          edge_cnt_next = '0;
          state_next    = S_STOP;
        end else begin
          edge_cnt_next = edge_inc;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          edge_cnt_next = '0;
          bit_cnt_next  = '0;
          tx_done_next  = 1'b1;
          state_next    = S_IDLE;
        end else begin
          edge_cnt_next = edge_inc;
        end
      end

      default: begin
        edge_cnt_next = '0;
        bit_cnt_next  = '0;
        state_next    = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the state being entered, so the registered line level
  // changes on the same edge as the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_out_next = 1'b1;
    busy_next   = (state_next != S_IDLE);
    case (state_next)
      S_START:  tx_out_next = 1'b0;
      S_DATA:   tx_out_next = data_next[bit_cnt_next];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_out_next = parity_bit;
`endif
      default:  tx_out_next = 1'b1;
    endcase
  end

  assign tx_out  = tx_out_reg;
  assign busy    = busy_reg;
  assign tx_done = tx_done_reg;

endmodule
